// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: datapath widths and load size/sign codes
// decoded in ID, carried through EX/MEM and consumed by the WB load extractor.
package mem_wb_stage_pkg;

   localparam int INST_SZ = 32;
   localparam int REG_SZ  = 5;
   localparam int CNT_SZ  = 32;

   // bhw[2] = unsigned, bhw[1:0] = size (00 byte, 01 half, 11 word)
   localparam logic [2:0] BHW_LB  = 3'b000;
   localparam logic [2:0] BHW_LH  = 3'b001;
   localparam logic [2:0] BHW_LW  = 3'b011;
   localparam logic [2:0] BHW_LBU = 3'b100;
   localparam logic [2:0] BHW_LHU = 3'b101;

   function automatic logic is_half_load(input logic [2:0] bhw);
      return (bhw == BHW_LH) || (bhw == BHW_LHU);
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational load extractor: selects the addressed byte/half of a little-endian
// word, sign/zero extends it, and flags misaligned half/word accesses.
module mem_wb_stage_load_ext
   import mem_wb_stage_pkg::*;
#(
   parameter int W = INST_SZ
) (
   input  logic [W-1:0] word,
   input  logic [1:0]   offset,
   input  logic [2:0]   bhw,
   output logic [W-1:0] data,
   output logic         misaligned
);

   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_lane[gi] = word[gi*8 +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign half_lane[gi] = word[gi*16 +: 16];
      end
   endgenerate

   assign byte_sel = byte_lane[offset];
   // A misaligned half still returns the half chosen by offset[1]
   assign half_sel = half_lane[offset[1]];

   always_comb begin
      data       = word;
      misaligned = 1'b0;
      case (bhw)
         BHW_LB:  data = {{(W-8){byte_sel[7]}}, byte_sel};
         BHW_LBU: data = {{(W-8){1'b0}}, byte_sel};
         BHW_LH:  data = {{(W-16){half_sel[15]}}, half_sel};
         BHW_LHU: data = {{(W-16){1'b0}}, half_sel};
         default: data = word;
      endcase
      if (is_half_load(bhw)) begin
         misaligned = offset[0];
      end else if (bhw == BHW_LW) begin
         misaligned = (offset != 2'b00);
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with WB-side load extraction, register-file write
// qualification, sticky halt and a retired-instruction counter for the debugger.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int INST_SZ = mem_wb_stage_pkg::INST_SZ,
   parameter int REG_SZ  = mem_wb_stage_pkg::REG_SZ,
   parameter int CNT_SZ  = mem_wb_stage_pkg::CNT_SZ
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_flush,
   input  logic [INST_SZ-1:0] i_alu_result_M,
   input  logic [INST_SZ-1:0] i_read_data_M,
   input  logic [REG_SZ-1:0]  i_write_reg_M,
   input  logic               i_reg_write_M,
   input  logic               i_mem_to_reg_M,
   input  logic [2:0]         i_bhw_M,
   input  logic               i_halt_M,
   output logic [INST_SZ-1:0] o_write_data_W,
   output logic [REG_SZ-1:0]  o_write_reg_W,
   output logic               o_reg_write_W,
   output logic               o_halt_W,
   output logic               o_misaligned_W,
   output logic [CNT_SZ-1:0]  o_retired_W
);

   logic [INST_SZ-1:0] alu_result_reg;
   logic [INST_SZ-1:0] read_data_reg;
   logic [REG_SZ-1:0]  write_reg_reg;
   logic               reg_write_reg;
   logic               mem_to_reg_reg;
   logic [2:0]         bhw_reg;
   logic               halt_instr_reg;
   logic               valid_reg;
   logic               halt_reg;
   logic               stop_reg;
   logic [CNT_SZ-1:0]  retired_reg;

   logic [INST_SZ-1:0] load_data;
   logic               load_misaligned;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         alu_result_reg <= '0;
         read_data_reg  <= '0;
         write_reg_reg  <= '0;
         reg_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         bhw_reg        <= '0;
         halt_instr_reg <= 1'b0;
         valid_reg      <= 1'b0;
      end else if (i_enable) begin
         if (i_flush) begin
            alu_result_reg <= '0;
            read_data_reg  <= '0;
            write_reg_reg  <= '0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            bhw_reg        <= '0;
            halt_instr_reg <= 1'b0;
            valid_reg      <= 1'b0;
         end else begin
            alu_result_reg <= i_alu_result_M;
            read_data_reg  <= i_read_data_M;
            write_reg_reg  <= i_write_reg_M;
            reg_write_reg  <= i_reg_write_M;
            mem_to_reg_reg <= i_mem_to_reg_M;
            bhw_reg        <= i_bhw_M;
            halt_instr_reg <= i_halt_M;
            valid_reg      <= 1'b1;
         end
      end
   end

   // Halt is sticky; the counter stops once the HALT itself has retired from WB
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         halt_reg    <= 1'b0;
         stop_reg    <= 1'b0;
         retired_reg <= '0;
      end else if (i_enable) begin
         if (!i_flush && i_halt_M) begin
            halt_reg <= 1'b1;
         end
         if (valid_reg && !stop_reg) begin
            retired_reg <= retired_reg + 1'b1;
            if (halt_instr_reg) begin
               stop_reg <= 1'b1;
            end
         end
      end
   end

   mem_wb_stage_load_ext #(
      .W (INST_SZ)
   ) u_load_ext (
      .word       (read_data_reg),
      .offset     (alu_result_reg[1:0]),
      .bhw        (bhw_reg),
      .data       (load_data),
      .misaligned (load_misaligned)
   );

   assign o_write_data_W = mem_to_reg_reg ? load_data : alu_result_reg;
   assign o_write_reg_W  = write_reg_reg;
   assign o_reg_write_W  = reg_write_reg && valid_reg && (write_reg_reg != '0) && !halt_reg;
   assign o_halt_W       = halt_reg;
   assign o_misaligned_W = load_misaligned && mem_to_reg_reg && valid_reg;
   assign o_retired_W    = retired_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each driven cycle pushes its expected WB
// outputs, which are popped and compared one cycle later.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        en;
   logic        fl;
   logic [31:0] alu;
   logic [31:0] rdata;
   logic [4:0]  rd;
   logic        rw;
   logic        m2r;
   logic [2:0]  bhw;
   logic        hlt;
   logic [31:0] wdata;
   logic [4:0]  wreg;
   logic        we;
   logic        halt_w;
   logic        misal;
   logic [31:0] retired;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  wreg;
      logic        we;
      logic        misal;
      logic        halt;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;

   int checks   = 0;
   int failures = 0;

   logic        m_valid;
   logic        m_halt;
   logic        m_halt_instr;
   logic        m_stop;
   logic [31:0] m_cnt;

   mem_wb_stage dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_enable       (en),
      .i_flush        (fl),
      .i_alu_result_M (alu),
      .i_read_data_M  (rdata),
      .i_write_reg_M  (rd),
      .i_reg_write_M  (rw),
      .i_mem_to_reg_M (m2r),
      .i_bhw_M        (bhw),
      .i_halt_M       (hlt),
      .o_write_data_W (wdata),
      .o_write_reg_W  (wreg),
      .o_reg_write_W  (we),
      .o_halt_W       (halt_w),
      .o_misaligned_W (misal),
      .o_retired_W    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_load(input logic [31:0] w, input logic [1:0] off,
                                    input logic [2:0] code, output logic [31:0] d,
                                    output logic m);
      logic [31:0] sb8;
      logic [31:0] sh16;
      sb8  = w >> {off, 3'b000};
      sh16 = w >> {off[1], 4'b0000};
      case (code)
         3'b000:  d = {{24{sb8[7]}}, sb8[7:0]};
         3'b100:  d = {24'h0, sb8[7:0]};
         3'b001:  d = {{16{sh16[15]}}, sh16[15:0]};
         3'b101:  d = {16'h0, sh16[15:0]};
         default: d = w;
      endcase
      if (code == 3'b001 || code == 3'b101) m = off[0];
      else if (code == 3'b011)              m = (off != 2'b00);
      else                                  m = 1'b0;
   endfunction

   task automatic check_outputs(input string tag, input exp_t e);
      check_val({tag, ".data"}, wdata, e.data);
      check_val({tag, ".wreg"}, {27'h0, wreg}, {27'h0, e.wreg});
      check_val({tag, ".we"}, {31'h0, we}, {31'h0, e.we});
      check_val({tag, ".misal"}, {31'h0, misal}, {31'h0, e.misal});
      check_val({tag, ".halt"}, {31'h0, halt_w}, {31'h0, e.halt});
      check_val({tag, ".cnt"}, retired, e.cnt);
   endtask

   task automatic step(input string tag, input logic e_en, input logic e_fl,
                       input logic [31:0] a, input logic [31:0] r, input logic [4:0] d,
                       input logic w, input logic m, input logic [2:0] b, input logic h);
      exp_t e;
      logic [31:0] ld;
      logic        mis;
      en = e_en; fl = e_fl; alu = a; rdata = r; rd = d; rw = w; m2r = m; bhw = b; hlt = h;
      e = last_exp;
      if (e_en) begin
         if (m_valid && !m_stop) begin
            m_cnt++;
            if (m_halt_instr) m_stop = 1'b1;
         end
         if (e_fl) begin
            m_valid = 1'b0;
            m_halt_instr = 1'b0;
            e.data = 32'h0; e.wreg = 5'h0; e.we = 1'b0; e.misal = 1'b0;
         end else begin
            m_valid = 1'b1;
            m_halt = m_halt | h;
            m_halt_instr = h;
            ref_load(r, a[1:0], b, ld, mis);
            e.data  = m ? ld : a;
            e.wreg  = d;
            e.we    = w && (d != 5'd0) && !m_halt;
            e.misal = m && mis;
         end
      end
      e.halt = m_halt;
      e.cnt  = m_cnt;
      last_exp = e;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_val({tag, ".sb_empty"}, 32'h1, 32'h0);
      end else begin
         e = sb.pop_front();
         check_outputs(tag, e);
      end
      $display("step %s en=%0b fl=%0b data=%h wreg=%0d we=%0b mis=%0b halt=%0b cnt=%0d",
               tag, e_en, e_fl, wdata, wreg, we, misal, halt_w, retired);
   endtask

   task automatic model_clear();
      m_valid = 1'b0; m_halt = 1'b0; m_halt_instr = 1'b0; m_stop = 1'b0; m_cnt = 32'h0;
      last_exp = '{32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 32'h0};
   endtask

   task automatic async_reset(input string tag);
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      check_outputs(tag, last_exp);
      $display("reset %s data=%h we=%0b halt=%0b cnt=%0d", tag, wdata, we, halt_w, retired);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; fl = 1'b0; alu = '0; rdata = '0; rd = '0;
      rw = 1'b0; m2r = 1'b0; bhw = '0; hlt = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("por", last_exp);
      @(negedge clk);
      rst = 1'b0;

      // Byte loads: byte 3 of 80FF_7F01 is 0x80, byte 2 is 0xFF
      step("lb_b3",  1, 0, 32'h0000_1003, 32'h80FF_7F01, 5'd5, 1, 1, 3'b000, 0);
      check_val("lb_b3.const", wdata, 32'hFFFF_FF80);
      step("lbu_b3", 1, 0, 32'h0000_1003, 32'h80FF_7F01, 5'd5, 1, 1, 3'b100, 0);
      check_val("lbu_b3.const", wdata, 32'h0000_0080);
      step("lb_b2",  1, 0, 32'h0000_1002, 32'h80FF_7F01, 5'd5, 1, 1, 3'b000, 0);
      check_val("lb_b2.const", wdata, 32'hFFFF_FFFF);
      step("lh",     1, 0, 32'h0000_1002, 32'h8001_7FFE, 5'd6, 1, 1, 3'b001, 0);
      check_val("lh.const", wdata, 32'hFFFF_8001);
      step("lhu",    1, 0, 32'h0000_1002, 32'h8001_7FFE, 5'd6, 1, 1, 3'b101, 0);
      check_val("lhu.const", wdata, 32'h0000_8001);
      step("lw_mis", 1, 0, 32'h0000_1001, 32'h8001_7FFE, 5'd7, 1, 1, 3'b011, 0);
      check_val("lw_mis.const", {31'h0, misal}, 32'h1);
      step("lh_mis", 1, 0, 32'h0000_1003, 32'h8001_7FFE, 5'd7, 1, 1, 3'b001, 0);
      step("lw_ok",  1, 0, 32'h0000_1004, 32'h8001_7FFE, 5'd7, 1, 1, 3'b011, 0);

      step("alu_r0", 1, 0, 32'h0000_1234, 32'hDEAD_BEEF, 5'd0, 1, 0, 3'b011, 0);
      check_val("alu_r0.const", {31'h0, we}, 32'h0);
      step("alu_r3", 1, 0, 32'h0000_1234, 32'hDEAD_BEEF, 5'd3, 1, 0, 3'b011, 0);
      check_val("alu_r3.const", {31'h0, we}, 32'h1);

      for (int i = 0; i < 3; i++) begin
         step("stall", 0, (i == 1), 32'hFFFF_FFFF, 32'h1111_1111, 5'd9, 1, 1, 3'b000, 1);
      end
      step("flush",      1, 1, 32'h5555_5555, 32'h6666_6666, 5'd4, 1, 0, 3'b011, 1);
      step("post_flush", 1, 0, 32'h0000_00A0, 32'h0, 5'd8, 1, 0, 3'b011, 0);
      step("flush2",     1, 1, 32'h0, 32'h0, 5'd8, 1, 0, 3'b011, 0);
      step("flush3",     1, 0, 32'h0000_00A4, 32'h0, 5'd8, 1, 0, 3'b011, 0);

      for (int i = 0; i < 24; i++) begin
         step("rand", 1, ($urandom_range(0, 5) == 0), $urandom, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0);
      end

      step("pre_rst", 1, 0, 32'h0000_0010, 32'h0, 5'd2, 1, 0, 3'b011, 0);
      async_reset("mid_rst");

      for (int i = 0; i < 4; i++) begin
         step("hrun", 1, 0, 32'h100 + 32'(i), 32'h0, 5'(10 + i), 1, 0, 3'b011, 0);
      end
      step("halt",   1, 0, 32'h0, 32'h0, 5'd0, 0, 0, 3'b011, 1);
      step("after1", 1, 0, 32'h0000_0200, 32'h0, 5'd12, 1, 0, 3'b011, 0);
      step("after2", 1, 0, 32'h0000_0204, 32'h0, 5'd13, 1, 1, 3'b000, 0);
      step("after3", 1, 1, 32'h0000_0208, 32'h0, 5'd14, 1, 0, 3'b011, 0);
      step("after4", 1, 0, 32'h0000_020C, 32'h0, 5'd15, 1, 0, 3'b011, 0);
      check_val("halt_cnt.const", retired, 32'd5);
      check_val("halt_sticky.const", {31'h0, halt_w}, 32'h1);
      check_val("halt_nowrite.const", {31'h0, we}, 32'h0);

      async_reset("final_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
